// File: rtl/spi_response_transmitter.sv
`default_nettype none
// ============================================================================
// Module : spi_response_transmitter
// Desc   : MISO-side serialiser for SD-card SPI responses and read data blocks.
//          Optional macro SPI_TX_CRC16_EN adds CRC16-CCITT over the payload.
// Rev    : 1.0  initial release
// ============================================================================

module spi_response_transmitter #(
  parameter int NCR_BYTES = 1,
  parameter int NAC_BYTES = 1,
  parameter int BLK_W     = 12
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_CLK,
  input  logic             io_CS,
  output logic             io_DO,
  input  logic             io_Start,
  input  logic [2:0]       io_RespLen,
  input  logic [39:0]      io_RespData,
  input  logic             io_SendBlock,
  input  logic [BLK_W-1:0] io_DataBlockSize,
  input  logic [7:0]       io_DataIn,
  input  logic             io_DataValid,
  output logic             io_DataReady,
  output logic             io_Busy,
  output logic             io_Done,
  output logic             io_Underrun
);

  localparam logic [2:0] c_ST_IDLE  = 3'd0;
  localparam logic [2:0] c_ST_NCR   = 3'd1;
  localparam logic [2:0] c_ST_RESP  = 3'd2;
  localparam logic [2:0] c_ST_NAC   = 3'd3;
  localparam logic [2:0] c_ST_TOKEN = 3'd4;
  localparam logic [2:0] c_ST_DATA  = 3'd5;
  localparam logic [2:0] c_ST_CRC   = 3'd6;
  localparam logic [2:0] c_ST_DONE  = 3'd7;

  localparam logic [BLK_W-1:0] c_ONE     = BLK_W'(1);
  localparam logic [BLK_W-1:0] c_TWO     = BLK_W'(2);
  localparam logic [BLK_W-1:0] c_NCR_CNT = BLK_W'(NCR_BYTES);
  localparam logic [BLK_W-1:0] c_NAC_CNT = BLK_W'(NAC_BYTES);

  logic [2:0]       r_state;
  logic [2:0]       w_next_state;
  logic [2:0]       w_after;
  logic [2:0]       w_target;
  logic [2:0]       r_clk_sync;
  logic [2:0]       r_cs_sync;
  logic [7:0]       r_shift;
  logic [2:0]       r_bit_cnt;
  logic [BLK_W-1:0] r_byte_cnt;
  logic [39:0]      r_resp;
  logic [2:0]       r_resp_len;
  logic             r_send_blk;
  logic [BLK_W-1:0] r_blk_size;
  logic [BLK_W-1:0] w_term;
  logic [2:0]       w_len_clamped;
  logic [7:0]       w_load_byte;
  logic [7:0]       w_payload;
  logic [7:0]       w_crc_hi;
  logic [7:0]       w_crc_lo;
  logic             w_cs;
  logic             w_cs_rise;
  logic             w_fall;
  logic             w_active;
  logic             w_abort;
  logic             w_adv;
  logic             w_byte_end;
  logic             w_last;
  logic             w_accept;
  logic             w_take;

  // Third flop vs second gives the edge; second flop is the synchronised level.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_clk_sync <= 3'b000;
      r_cs_sync  <= 3'b111;
    end else begin
      r_clk_sync <= {r_clk_sync[1:0], io_CLK};
      r_cs_sync  <= {r_cs_sync[1:0], io_CS};
    end
  end

  assign w_cs       = r_cs_sync[1];
  assign w_cs_rise  = r_cs_sync[1] & ~r_cs_sync[2];
  assign w_fall     = r_clk_sync[2] & ~r_clk_sync[1];
  assign w_active   = (r_state != c_ST_IDLE) && (r_state != c_ST_DONE);
  assign w_abort    = w_active && w_cs_rise;
  assign w_adv      = w_active && w_fall && !w_cs;
  assign w_byte_end = w_adv && (r_bit_cnt == 3'd7);
  assign w_accept   = (r_state == c_ST_IDLE) && io_Start;
  assign w_last     = (r_byte_cnt == (w_term - c_ONE));
  assign w_payload  = io_DataValid ? io_DataIn : 8'hFF;

  assign w_len_clamped = (io_RespLen == 3'd0) ? 3'd1 :
                         (io_RespLen > 3'd5)  ? 3'd5 : io_RespLen;

  always_comb begin
    w_term = c_ONE;
    case (r_state)
      c_ST_NCR:  w_term = c_NCR_CNT;
      c_ST_RESP: w_term = BLK_W'(r_resp_len);
      c_ST_NAC:  w_term = c_NAC_CNT;
      c_ST_DATA: w_term = r_blk_size;
      c_ST_CRC:  w_term = c_TWO;
      default:   w_term = c_ONE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_after = c_ST_DONE;
    case (r_state)
      c_ST_NCR:   w_after = c_ST_RESP;
      c_ST_RESP:  w_after = r_send_blk ? ((NAC_BYTES > 0) ? c_ST_NAC : c_ST_TOKEN) : c_ST_DONE;
      c_ST_NAC:   w_after = c_ST_TOKEN;
      c_ST_TOKEN: w_after = (r_blk_size != '0) ? c_ST_DATA : c_ST_CRC;
      c_ST_DATA:  w_after = c_ST_CRC;
      default:    w_after = c_ST_DONE;
    endcase

    w_next_state = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (io_Start) w_next_state = (NCR_BYTES > 0) ? c_ST_NCR : c_ST_RESP;
      end
      c_ST_DONE: w_next_state = c_ST_IDLE;
      default: begin
        if (w_abort)                 w_next_state = c_ST_IDLE;
        else if (w_byte_end && w_last) w_next_state = w_after;
      end
    endcase
  end

  // The byte loaded at a boundary is the first byte of whatever state follows.
  always_comb begin
    io_Busy      = w_active;
    io_Done      = (r_state == c_ST_DONE);
    io_DO        = (w_active && !w_cs) ? r_shift[7] : 1'b1;
    w_target     = w_last ? w_after : r_state;
    w_take       = w_byte_end && (w_target == c_ST_DATA);
    io_DataReady = w_take;
    io_Underrun  = w_take && !io_DataValid;
    case (w_target)
      c_ST_RESP:  w_load_byte = r_resp[39:32];
      c_ST_TOKEN: w_load_byte = 8'hFE;
      c_ST_DATA:  w_load_byte = w_payload;
      c_ST_CRC:   w_load_byte = (r_state == c_ST_CRC) ? w_crc_lo : w_crc_hi;
      default:    w_load_byte = 8'hFF;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_shift    <= 8'hFF;
      r_bit_cnt  <= 3'd0;
      r_byte_cnt <= '0;
      r_resp     <= '0;
      r_resp_len <= 3'd0;
      r_send_blk <= 1'b0;
      r_blk_size <= '0;
    end else if (w_abort) begin
      r_shift    <= 8'hFF;
      r_bit_cnt  <= 3'd0;
      r_byte_cnt <= '0;
    end else if (w_accept) begin
      r_resp_len <= w_len_clamped;
      r_send_blk <= io_SendBlock;
      r_blk_size <= io_DataBlockSize;
      r_bit_cnt  <= 3'd0;
      r_byte_cnt <= '0;
      if (NCR_BYTES > 0) begin
        r_shift <= 8'hFF;
        r_resp  <= io_RespData;
      end else begin
        r_shift <= io_RespData[39:32];
        r_resp  <= {io_RespData[31:0], 8'h00};
      end
    end else if (w_adv) begin
      if (r_bit_cnt == 3'd7) begin
        r_shift    <= w_load_byte;
        r_bit_cnt  <= 3'd0;
        r_byte_cnt <= w_last ? '0 : (r_byte_cnt + c_ONE);
        if (w_target == c_ST_RESP) r_resp <= {r_resp[31:0], 8'h00};
      end else begin
        r_shift   <= {r_shift[6:0], 1'b1};
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
    end
  end

`ifdef SPI_TX_CRC16_EN
  logic [15:0] r_crc;

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] d);
    logic [15:0] c;
    c = crc ^ {d, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
    end
    return c;
  endfunction

  // Substituted 0xFF bytes are folded in because they are what the host receives.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_crc <= 16'h0000;
    end else if (w_accept) begin
      r_crc <= 16'h0000;
    end else if (w_take) begin
      r_crc <= crc16_byte(r_crc, w_payload);
    end
  end

  assign w_crc_hi = r_crc[15:8];
  assign w_crc_lo = r_crc[7:0];
`else
  assign w_crc_hi = 8'hFF;
  assign w_crc_lo = 8'hFF;
`endif

endmodule

`default_nettype wire

// File: tb/tb_spi_response_transmitter.sv
`default_nettype none
// Bench for spi_response_transmitter: table vectors, random transactions vs a
// byte-stream reference model, plus reset / abort / deferred-CS sequences.

module tb_spi_response_transmitter;

  localparam int c_NCR   = 1;
  localparam int c_NAC   = 1;
  localparam int c_BLK_W = 12;

  logic              clock;
  logic              reset;
  logic              io_CLK;
  logic              io_CS;
  logic              io_DO;
  logic              io_Start;
  logic [2:0]        io_RespLen;
  logic [39:0]       io_RespData;
  logic              io_SendBlock;
  logic [c_BLK_W-1:0] io_DataBlockSize;
  logic [7:0]        io_DataIn;
  logic              io_DataValid;
  logic              io_DataReady;
  logic              io_Busy;
  logic              io_Done;
  logic              io_Underrun;

  spi_response_transmitter #(
    .NCR_BYTES(c_NCR),
    .NAC_BYTES(c_NAC),
    .BLK_W    (c_BLK_W)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .io_CLK          (io_CLK),
    .io_CS           (io_CS),
    .io_DO           (io_DO),
    .io_Start        (io_Start),
    .io_RespLen      (io_RespLen),
    .io_RespData     (io_RespData),
    .io_SendBlock    (io_SendBlock),
    .io_DataBlockSize(io_DataBlockSize),
    .io_DataIn       (io_DataIn),
    .io_DataValid    (io_DataValid),
    .io_DataReady    (io_DataReady),
    .io_Busy         (io_Busy),
    .io_Done         (io_Done),
    .io_Underrun     (io_Underrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  len;
    logic [39:0] data;
    bit          sb;
    int          size;
    logic [31:0] pay;
    logic [3:0]  vld;
    int          mode;
    logic [63:0] pre;
    int          npre;
    int          rdy;
    int          und;
  } vec_t;

  vec_t vecs[9];

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  int rdy_cnt  = 0;
  int und_cnt  = 0;
  int exp_rdy  = 0;
  int exp_und  = 0;
  int feed_idx = 0;

  logic [7:0] feed_data[$];
  bit         feed_valid[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic check_stream(input string name);
    int bad;
    bad = -1;
    n_checks++;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (bad < 0 && (i >= got_q.size() || got_q[i] !== exp_q[i])) bad = i;
    end
    if (bad >= 0)
      $display("FAIL %s stream: byte %0d got %02h expected %02h", name, bad,
               (bad < got_q.size()) ? got_q[bad] : 8'h00, exp_q[bad]);
    else n_pass++;
  endtask

  task automatic apply_feed();
    if (feed_idx < feed_data.size()) begin
      io_DataIn    = feed_data[feed_idx];
      io_DataValid = feed_valid[feed_idx];
    end else begin
      io_DataIn    = 8'h00;
      io_DataValid = 1'b0;
    end
  endtask

  // Pulse counters and payload source: next byte appears after each consume.
  initial begin
    forever begin
      @(negedge clock);
      if (io_Done) done_cnt++;
      if (io_Underrun) und_cnt++;
      if (io_DataReady) begin
        rdy_cnt++;
        @(posedge clock);
        #1;
        feed_idx++;
        apply_feed();
      end
    end
  end

  function automatic logic [15:0] crc_of(input int first, input int cnt);
    logic [15:0] c;
    logic        fb;
    c = 16'h0000;
`ifdef SPI_TX_CRC16_EN
    for (int k = 0; k < cnt; k++) begin
      for (int b = 7; b >= 0; b--) begin
        fb = c[15] ^ exp_q[first + k][b];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
    end
`else
    fb = 1'b0;
    if (first >= 0 && cnt >= 0) c = 16'hFFFF;
`endif
    return c;
  endfunction

  task automatic append_crc(input int first, input int cnt);
    logic [15:0] c;
    c = crc_of(first, cnt);
    exp_q.push_back(c[15:8]);
    exp_q.push_back(c[7:0]);
  endtask

  // Reference: the byte stream a host should see for one transaction.
  task automatic build_expected(input logic [2:0] len, input logic [39:0] data,
                                input bit sb, input int size);
    int n;
    int first;
    exp_q.delete();
    n = (len == 3'd0) ? 1 : ((len > 3'd5) ? 5 : int'(len));
    for (int i = 0; i < c_NCR; i++) exp_q.push_back(8'hFF);
    for (int i = 0; i < n; i++) exp_q.push_back(8'(data >> (8 * (4 - i))));
    exp_rdy = 0;
    exp_und = 0;
    if (sb) begin
      for (int i = 0; i < c_NAC; i++) exp_q.push_back(8'hFF);
      exp_q.push_back(8'hFE);
      first = exp_q.size();
      for (int i = 0; i < size; i++) begin
        if (feed_valid[i]) exp_q.push_back(feed_data[i]);
        else begin
          exp_q.push_back(8'hFF);
          exp_und++;
        end
      end
      exp_rdy = size;
      append_crc(first, size);
    end
  endtask

  task automatic spi_bit(output logic b);
    io_CLK = 1'b1;
    b = io_DO;
    repeat (8) @(negedge clock);
    io_CLK = 1'b0;
    repeat (8) @(negedge clock);
  endtask

  // mode 0: plain, 1: extra Start while busy, 2: Start accepted with CS high.
  task automatic run_txn(input logic [2:0] len, input logic [39:0] data, input bit sb,
                         input int size, input int mode, input string tag);
    logic [7:0] byte_v;
    logic       b;
    got_q.delete();
    feed_idx = 0;
    apply_feed();
    io_CLK = 1'b0;
    io_CS  = (mode == 2) ? 1'b1 : 1'b0;
    repeat (4) @(negedge clock);
    done_cnt = 0;
    rdy_cnt  = 0;
    und_cnt  = 0;
    io_RespLen       = len;
    io_RespData      = data;
    io_SendBlock     = sb;
    io_DataBlockSize = 12'(size);
    io_Start = 1'b1;
    @(negedge clock);
    io_Start = 1'b0;
    check({tag, " busy after start"}, io_Busy, 1);
    if (mode == 2) begin
      repeat (20) @(negedge clock);
      check({tag, " busy while CS high"}, io_Busy, 1);
      check({tag, " DO while CS high"}, io_DO, 1);
      io_CS = 1'b0;
      repeat (4) @(negedge clock);
    end
    byte_v = 8'h00;
    for (int i = 0; i < exp_q.size(); i++) begin
      for (int j = 0; j < 8; j++) begin
        if (mode == 1 && i == 0 && j == 4) begin
          io_RespLen  = 3'd5;
          io_RespData = 40'hAA55AA55AA;
          io_Start    = 1'b1;
          @(negedge clock);
          io_Start = 1'b0;
          @(negedge clock);
        end
        spi_bit(b);
        byte_v = {byte_v[6:0], b};
      end
      got_q.push_back(byte_v);
    end
    repeat (4) @(negedge clock);
    check_stream(tag);
    check({tag, " done pulses"}, 64'(done_cnt), 1);
    check({tag, " ready pulses"}, 64'(rdy_cnt), 64'(exp_rdy));
    check({tag, " underrun pulses"}, 64'(und_cnt), 64'(exp_und));
    check({tag, " idle busy"}, io_Busy, 0);
    check({tag, " idle DO"}, io_DO, 1);
    io_CS = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  initial begin
    vec_t        v;
    logic [11:0] bits;
    logic        b;
    logic [2:0]  rl;
    logic [39:0] rd;
    bit          rsb;
    int          rsz;

    vecs[0] = '{3'd1, 40'h01_0000_0000, 1'b0, 0, 32'h0,        4'h0,    0, 64'hFF01_0000_0000_0000, 2, 0, 0};
    vecs[1] = '{3'd5, 40'h00_0000_01AA, 1'b0, 0, 32'h0,        4'h0,    0, 64'hFF00_0000_01AA_0000, 6, 0, 0};
    vecs[2] = '{3'd1, 40'h00_0000_0000, 1'b1, 4, 32'h12345678, 4'b1111, 0, 64'hFF00_FFFE_1234_5678, 8, 4, 0};
    vecs[3] = '{3'd1, 40'h00_0000_0000, 1'b1, 4, 32'h12345678, 4'b1011, 0, 64'hFF00_FFFE_1234_FF78, 8, 4, 1};
    vecs[4] = '{3'd0, 40'h7F_0000_0000, 1'b0, 0, 32'h0,        4'h0,    0, 64'hFF7F_0000_0000_0000, 2, 0, 0};
    vecs[5] = '{3'd7, 40'h01_0203_0405, 1'b0, 0, 32'h0,        4'h0,    0, 64'hFF01_0203_0405_0000, 6, 0, 0};
    vecs[6] = '{3'd1, 40'h00_0000_0000, 1'b1, 0, 32'h0,        4'h0,    0, 64'hFF00_FFFE_0000_0000, 4, 0, 0};
    vecs[7] = '{3'd1, 40'h05_0000_0000, 1'b0, 0, 32'h0,        4'h0,    1, 64'hFF05_0000_0000_0000, 2, 0, 0};
    vecs[8] = '{3'd1, 40'h01_0000_0000, 1'b0, 0, 32'h0,        4'h0,    2, 64'hFF01_0000_0000_0000, 2, 0, 0};

    reset = 1'b0;
    io_CLK = 1'b0;
    io_CS = 1'b1;
    io_Start = 1'b0;
    io_RespLen = 3'd0;
    io_RespData = '0;
    io_SendBlock = 1'b0;
    io_DataBlockSize = '0;
    io_DataIn = 8'h00;
    io_DataValid = 1'b0;
    repeat (4) @(negedge clock);
    reset = 1'b1;
    repeat (4) @(negedge clock);
    check("reset DO", io_DO, 1);
    check("reset busy", io_Busy, 0);
    check("reset done", io_Done, 0);
    check("reset ready", io_DataReady, 0);
    check("reset underrun", io_Underrun, 0);

    for (int i = 0; i < 9; i++) begin
      v = vecs[i];
      feed_data.delete();
      feed_valid.delete();
      for (int j = 0; j < v.size; j++) begin
        feed_data.push_back(v.pay[31 - 8 * j -: 8]);
        feed_valid.push_back(v.vld[j]);
      end
      exp_q.delete();
      for (int j = 0; j < v.npre; j++) exp_q.push_back(v.pre[63 - 8 * j -: 8]);
      if (v.sb) append_crc(v.npre - v.size, v.size);
      exp_rdy = v.rdy;
      exp_und = v.und;
      run_txn(v.len, v.data, v.sb, v.size, v.mode, $sformatf("vec%0d", i));
    end

    // Reset asserted in the middle of the response byte.
    feed_data.delete();
    feed_valid.delete();
    io_CS = 1'b0;
    repeat (4) @(negedge clock);
    done_cnt = 0;
    io_RespLen = 3'd1;
    io_RespData = 40'h00_0000_0000;
    io_SendBlock = 1'b0;
    io_Start = 1'b1;
    @(negedge clock);
    io_Start = 1'b0;
    for (int i = 0; i < 11; i++) spi_bit(b);
    check("pre-reset DO low", io_DO, 0);
    reset = 1'b0;
    #1;
    check("async reset DO", io_DO, 1);
    check("async reset busy", io_Busy, 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    io_CS = 1'b1;
    repeat (6) @(negedge clock);
    check("post-reset DO", io_DO, 1);
    check("post-reset busy", io_Busy, 0);
    check("post-reset done", 64'(done_cnt), 0);

    // CS raised after 12 bits of a 5-byte response.
    io_CS = 1'b0;
    repeat (4) @(negedge clock);
    done_cnt = 0;
    io_RespLen = 3'd5;
    io_RespData = 40'h00_0000_01AA;
    io_Start = 1'b1;
    @(negedge clock);
    io_Start = 1'b0;
    bits = 12'h000;
    for (int i = 0; i < 12; i++) begin
      spi_bit(b);
      bits = {bits[10:0], b};
    end
    check("abort prefix bits", bits, 12'hFF0);
    io_CS = 1'b1;
    repeat (4) @(negedge clock);
    check("abort DO", io_DO, 1);
    check("abort busy", io_Busy, 0);
    repeat (30) @(negedge clock);
    check("abort no done", 64'(done_cnt), 0);
    feed_data.delete();
    feed_valid.delete();
    build_expected(3'd1, 40'h01_0000_0000, 1'b0, 0);
    run_txn(3'd1, 40'h01_0000_0000, 1'b0, 0, 0, "after abort");

    for (int t = 0; t < 8; t++) begin
      rl  = 3'($urandom_range(0, 7));
      rd  = {8'($urandom), 32'($urandom)};
      rsb = 1'($urandom_range(0, 1));
      rsz = $urandom_range(0, 5);
      feed_data.delete();
      feed_valid.delete();
      for (int j = 0; j < rsz; j++) begin
        feed_data.push_back(8'($urandom));
        feed_valid.push_back($urandom_range(0, 3) != 0);
      end
      build_expected(rl, rd, rsb, rsz);
      run_txn(rl, rd, rsb, rsz, 0, $sformatf("rand%0d", t));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
